drum_sequencer: RTL and testbench

Sixteen-step pattern sequencer that schedules the per-voice sample counters (kick, snare, hat, cymbal) in the drum machine. It holds a writable on/off pattern per voice and step, divides the audio sample strobe into steps of programmable length, and drives each voice counter's `go` trigger and `en` advance inputs. It sits between the user-input/pattern-entry logic and the voice counters.

---
 rtl/drum_sequencer.sv | 156 +++++++++++++++
 tb/tb_drum_sequencer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_sequencer.sv
// drum_sequencer: sixteen-step pattern sequencer driving the per-voice
// sample counters of the drum machine.
//
// Ports:
//   clk          system clock, rising edge
//   resetn       asynchronous active-low reset
//   sample_tick  one-cycle strobe at the audio sample rate
//   run          level: 1 = play, 0 = stop
//   step_len     sample ticks per step (0 behaves as 1)
//   mute         per-voice mute, level
//   pat_we       pattern write strobe
//   pat_voice    voice index for the pattern write
//   pat_step     step index for the pattern write
//   pat_bit      value to write
//   go           one-cycle trigger per voice at each step start
//   en           per-voice sample-advance enable (combinational)
//   step         current step index
//   beat         one-cycle pulse at each step start
//   playing      high while the FSM is in PLAY
//
// state  | meaning
// S_IDLE | stopped: step, tick counter and pulses held at 0
// S_PLAY | counting sample ticks and stepping through the pattern
module drum_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int NUM_STEPS  = 16,
    parameter int STEP_W     = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sample_tick,
    input  logic                  run,
    input  logic [15:0]           step_len,
    input  logic [NUM_VOICES-1:0] mute,
    input  logic                  pat_we,
    input  logic [1:0]            pat_voice,
    input  logic [STEP_W-1:0]     pat_step,
    input  logic                  pat_bit,
    output logic [NUM_VOICES-1:0] go,
    output logic [NUM_VOICES-1:0] en,
    output logic [STEP_W-1:0]     step,
    output logic                  beat,
    output logic                  playing
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [STEP_W-1:0]     r_step, w_step_nxt;
    logic [15:0]           r_tick, w_tick_nxt;
    logic [15:0]           r_len, w_len_nxt;
    logic [NUM_VOICES-1:0] r_go, w_go_nxt;
    logic                  r_beat, w_beat_nxt;
    logic [NUM_STEPS-1:0]  r_pat [NUM_VOICES];

    logic [15:0]           w_len_in;
    logic [STEP_W-1:0]     w_step_inc;
    logic                  w_boundary;
    logic [NUM_VOICES-1:0] w_col_first;
    logic [NUM_VOICES-1:0] w_col_next;

    assign w_len_in   = (step_len == 16'd0) ? 16'd1 : step_len;
    assign w_step_inc = r_step + 1'b1;  // power-of-two step count wraps for free
    assign w_boundary = sample_tick && (r_tick == r_len - 16'd1);

    // Pattern columns are read from the registered array, so a write landing
    // on the same edge as a trigger is only seen on the next visit.
    always_comb begin
        w_col_first = '0;
        w_col_next  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_col_first[v] = r_pat[v][0];
            w_col_next[v]  = r_pat[v][w_step_inc];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_tick_nxt  = r_tick;
        w_len_nxt   = r_len;
        w_go_nxt    = '0;
        w_beat_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_step_nxt = '0;
                w_tick_nxt = '0;
                if (run) begin
                    w_state_nxt = S_PLAY;
                    w_go_nxt    = w_col_first & ~mute;
                    w_beat_nxt  = 1'b1;
                    w_len_nxt   = w_len_in;
                end
            end
            S_PLAY: begin
                if (!run) begin
                    // stop wins over a coincident boundary
                    w_state_nxt = S_IDLE;
                    w_step_nxt  = '0;
                    w_tick_nxt  = '0;
                end else if (w_boundary) begin
                    w_tick_nxt = '0;
                    w_step_nxt = w_step_inc;
                    w_go_nxt   = w_col_next & ~mute;
                    w_beat_nxt = 1'b1;
                    w_len_nxt  = w_len_in;
                end else if (sample_tick) begin
                    w_tick_nxt = r_tick + 16'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_step  <= '0;
            r_tick  <= '0;
            r_len   <= 16'd1;
            r_go    <= '0;
            r_beat  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_tick  <= w_tick_nxt;
            r_len   <= w_len_nxt;
            r_go    <= w_go_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_pat[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (pat_we && (pat_voice == 2'(v))) begin
                    r_pat[v][pat_step] <= pat_bit;
                end
            end
        end
    end

    assign go      = r_go;
    assign beat    = r_beat;
    assign step    = r_step;
    assign playing = (r_state == S_PLAY);
    assign en      = {NUM_VOICES{sample_tick & playing}} & ~mute;

endmodule

// File: tb/tb_drum_sequencer.sv
module tb_drum_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        sample_tick;
    logic        run;
    logic [15:0] step_len;
    logic [3:0]  mute;
    logic        pat_we;
    logic [1:0]  pat_voice;
    logic [3:0]  pat_step;
    logic        pat_bit;
    logic [3:0]  go;
    logic [3:0]  en;
    logic [3:0]  step;
    logic        beat;
    logic        playing;

    int n_cmp  = 0;
    int n_fail = 0;

    drum_sequencer #(.NUM_VOICES(4), .NUM_STEPS(16), .STEP_W(4)) dut (
        .clk(clk), .resetn(resetn), .sample_tick(sample_tick), .run(run),
        .step_len(step_len), .mute(mute), .pat_we(pat_we), .pat_voice(pat_voice),
        .pat_step(pat_step), .pat_bit(pat_bit), .go(go), .en(en), .step(step),
        .beat(beat), .playing(playing)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    // Step timing is counted as "ticks seen in this step"; a step ends when
    // that count reaches the length latched at its start.
    bit        m_pat [4][16];
    bit        m_play;
    int        m_step, m_cnt, m_len;
    logic [3:0] m_go;
    bit        m_beat;

    function automatic void model_reset();
        for (int v = 0; v < 4; v++)
            for (int s = 0; s < 16; s++) m_pat[v][s] = 0;
        m_play = 0; m_step = 0; m_cnt = 0; m_len = 1; m_go = '0; m_beat = 0;
    endfunction

    function automatic logic [3:0] trig(int s);
        logic [3:0] c;
        for (int v = 0; v < 4; v++) c[v] = m_pat[v][s] & ~mute[v];
        return c;
    endfunction

    function automatic void model_edge();
        int L;
        if (!resetn) begin
            model_reset();
            return;
        end
        L = (step_len == 16'd0) ? 1 : int'(step_len);
        m_go = '0;
        m_beat = 0;
        if (!m_play) begin
            if (run) begin
                m_play = 1; m_step = 0; m_cnt = 0; m_len = L;
                m_go = trig(0); m_beat = 1;
            end
        end else if (!run) begin
            m_play = 0; m_step = 0; m_cnt = 0;
        end else if (sample_tick) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == m_len) begin
                m_cnt = 0;
                m_step = (m_step + 1) % 16;
                m_go = trig(m_step);
                m_beat = 1;
                m_len = L;
            end
        end
        if (pat_we) m_pat[pat_voice][pat_step] = pat_bit;
    endfunction

    function automatic logic [13:0] exp_vec();
        logic [3:0] e;
        e = (sample_tick && m_play) ? ~mute : 4'b0000;
        return {m_go, e, 4'(m_step), m_beat, m_play};
    endfunction

    logic [13:0] obs;
    assign obs = {go, en, step, beat, playing};

    task automatic clk1();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        sample_tick = 0; run = 0; step_len = 16'd1; mute = '0;
        pat_we = 0; pat_voice = '0; pat_step = '0; pat_bit = 0;
    endtask

    task automatic write_pat(int v, int s, bit b);
        pat_we = 1; pat_voice = 2'(v); pat_step = 4'(s); pat_bit = b;
        clk1();
        pat_we = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        resetn = 0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            sample_tick = 1'($urandom); run = 1'($urandom); step_len = 16'($urandom);
            pat_we = 1'($urandom); pat_voice = 2'($urandom); pat_step = 4'($urandom);
            pat_bit = 1'($urandom); mute = 4'($urandom);
            clk1();
            n_cmp++;
            if ({go, step, beat, playing} !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h want 0", {go, step, beat, playing});
            end
        end
        idle_inputs();
        clk1();
        resetn = 1;
        n_cmp++;
        if (obs !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h want 0", obs);
        end
        sample_tick = 1; step_len = 16'd1; run = 1;
        for (int i = 0; i < 20; i++) begin
            clk1();
            n_cmp++;
            if (go !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_pattern_empty: go got %b want 0000", go);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_play_model: got %h want %h", obs, exp_vec());
            end
        end
        run = 0;
        clk1();
    endtask

    task automatic test_basic_play();
        idle_inputs();
        write_pat(0, 0, 1); write_pat(0, 4, 1); write_pat(0, 8, 1);
        write_pat(0, 12, 1); write_pat(3, 2, 1);
        step_len = 16'd4; sample_tick = 1; run = 1;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            clk1();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic_model c%0d: got %h want %h", cyc, obs, exp_vec());
            end
            n_cmp++;
            if (go[0] !== ((cyc - 1) % 16 == 0)) begin
                n_fail++;
                $display("FAIL basic_go0 c%0d: got %b want %b", cyc, go[0], (cyc - 1) % 16 == 0);
            end
            n_cmp++;
            if (go[3] !== (cyc == 9)) begin
                n_fail++;
                $display("FAIL basic_go3 c%0d: got %b want %b", cyc, go[3], cyc == 9);
            end
            n_cmp++;
            if (beat !== ((cyc - 1) % 4 == 0)) begin
                n_fail++;
                $display("FAIL basic_beat c%0d: got %b want %b", cyc, beat, (cyc - 1) % 4 == 0);
            end
            n_cmp++;
            if (step !== 4'(((cyc - 1) / 4) % 16)) begin
                n_fail++;
                $display("FAIL basic_step c%0d: got %0d want %0d", cyc, step, ((cyc - 1) / 4) % 16);
            end
        end
    endtask

    task automatic test_stop_restart();
        int n = 0;
        while (step !== 4'd5 && n < 200) begin
            clk1();
            n++;
        end
        n_cmp++;
        if (step !== 4'd5) begin
            n_fail++;
            $display("FAIL stop_reach_step5: got %0d want 5", step);
        end
        run = 0;
        clk1();
        n_cmp++;
        if ({step, playing, en} !== 9'd0) begin
            n_fail++;
            $display("FAIL stop_clear: got step=%0d playing=%b en=%b want 0/0/0", step, playing, en);
        end
        run = 1;
        clk1();
        n_cmp++;
        if ({go, beat, step} !== {4'b0001, 1'b1, 4'd0}) begin
            n_fail++;
            $display("FAIL restart_go: got go=%b beat=%b step=%0d want 0001/1/0", go, beat, step);
        end
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL restart_model: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_len_edges();
        bit prev_tick;
        run = 0;
        clk1();
        step_len = 16'd0; run = 1; sample_tick = 1;
        clk1();
        for (int i = 0; i < 40; i++) begin
            prev_tick = sample_tick;
            sample_tick = 1'($urandom);
            prev_tick = sample_tick;
            clk1();
            n_cmp++;
            if (beat !== prev_tick) begin
                n_fail++;
                $display("FAIL len0_beat i%0d: got %b want %b", i, beat, prev_tick);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL len0_model i%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        run = 0;
        clk1();
        step_len = 16'd4; sample_tick = 1; run = 1;
        clk1();
        clk1();
        step_len = 16'd2;
        for (int i = 2; i <= 7; i++) begin
            clk1();
            n_cmp++;
            if (step !== 4'((i < 4) ? 0 : (i - 4) / 2 + 1)) begin
                n_fail++;
                $display("FAIL len_change e%0d: got %0d want %0d", i, step, (i < 4) ? 0 : (i - 4) / 2 + 1);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL len_change_model e%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_same_cycle_write();
        run = 0;
        clk1();
        step_len = 16'd1; sample_tick = 1; run = 1;
        clk1(); clk1(); clk1();
        n_cmp++;
        if (step !== 4'd2) begin
            n_fail++;
            $display("FAIL rbw_setup: step got %0d want 2", step);
        end
        pat_we = 1; pat_voice = 2'd1; pat_step = 4'd3; pat_bit = 1;
        clk1();
        pat_we = 0;
        n_cmp++;
        if ({step, go[1]} !== {4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL rbw_old_bit: got step=%0d go1=%b want 3/0", step, go[1]);
        end
        for (int i = 0; i < 16; i++) begin
            clk1();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rbw_model i%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({step, go[1]} !== {4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL rbw_new_bit: got step=%0d go1=%b want 3/1", step, go[1]);
        end
    endtask

    task automatic test_mute();
        run = 0;
        clk1();
        for (int s = 0; s < 4; s++) begin
            write_pat(0, s, 1);
            write_pat(2, s, 1);
        end
        mute = 4'b0001; step_len = 16'd1; run = 1;
        for (int i = 0; i < 40; i++) begin
            sample_tick = 1'($urandom);
            clk1();
            n_cmp++;
            if ({go[0], en[0]} !== 2'b00) begin
                n_fail++;
                $display("FAIL mute_v0: got go0=%b en0=%b want 0/0", go[0], en[0]);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL mute_model i%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        mute = 4'b0000;
    endtask

    task automatic test_reset_midplay();
        int n = 0;
        sample_tick = 1;
        while (step !== 4'd7 && n < 100) begin
            clk1();
            n++;
        end
        n_cmp++;
        if (step !== 4'd7) begin
            n_fail++;
            $display("FAIL rst_reach_step7: got %0d want 7", step);
        end
        #2 resetn = 0;
        #1;
        n_cmp++;
        if ({go, step, beat, playing, en} !== 14'd0) begin
            n_fail++;
            $display("FAIL rst_async: got %h want 0", {go, step, beat, playing, en});
        end
        model_reset();
        clk1();
        resetn = 1;
        for (int i = 0; i < 40; i++) begin
            clk1();
            n_cmp++;
            if (go !== 4'b0000) begin
                n_fail++;
                $display("FAIL rst_empty_go i%0d: got %b want 0000", i, go);
            end
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL rst_resume_model i%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            run         = ($urandom_range(0, 19) != 0);
            sample_tick = 1'($urandom);
            step_len    = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) mute = 4'($urandom);
            pat_we      = ($urandom_range(0, 2) == 0);
            pat_voice   = 2'($urandom);
            pat_step    = 4'($urandom);
            pat_bit     = 1'($urandom);
            clk1();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model i%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_play();
        test_stop_restart();
        test_len_edges();
        test_same_cycle_write();
        test_mute();
        test_reset_midplay();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
